inst_encoder_loader: RTL

- Inverse of the core's immediate generator: packs register fields, funct3 and an immediate into 32-bit LW (I), SW (S) and BEQ (B) instruction words.
- Buffers encoded words in a small FIFO and streams them into instruction memory over a req/gnt write port with an auto-incrementing address.
- Used as the program loader that fills instruction memory before the pipeline is released from reset.

---
 rtl/inst_encoder_loader.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/inst_encoder_loader.sv
// inst_encoder_loader
//
// Program loader for instruction memory. Each request is packed into a 32-bit
// RV32 instruction word for one of three formats: LW (I), SW (S) or BEQ (B).
// The word is held in a small FIFO and then written into instruction memory
// over a req/gnt port. The write address starts at BASE_ADDR and advances by
// 4 on every granted write.
//
// The B-format immediate arrives in halfword units. Its bits are therefore
// placed one position lower than the raw RISC-V byte offset, so the word
// round-trips through the core's immediate generator.
//
// Optional feature:
//   `define IMM_RANGE_CHECK_EN
//     Rejects immediates outside [-2048, 2047]. A rejected request is
//     accepted and dropped, and err is set. Without the macro, the upper
//     immediate bits are truncated and the word is still pushed.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   encode request handshake
//   in_fmt              0=I (LW), 1=S (SW), 2=B (BEQ), 3=reserved (dropped, sets err)
//   in_rd/in_rs1/in_rs2 register fields
//   in_funct3           funct3 field
//   in_imm              signed immediate (B format in halfword units)
//   in_last             tags the final instruction of the program
//   mem_req/mem_gnt     instruction-memory write handshake
//   mem_addr/mem_wdata  write byte address and encoded word (FIFO head)
//   done                one-cycle pulse after the last-tagged word is written
//   err                 sticky: reserved format or immediate out of range
//   wrap                sticky: write address counter wrapped to BASE_ADDR

module inst_encoder_loader #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_fmt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              mem_req,
    input  logic              mem_gnt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              done,
    output logic              err,
    output logic              wrap
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // ------------------------------------------------------------------
    // Encoder
    // ------------------------------------------------------------------
    logic [31:0] enc_word;
    logic        fmt_bad;
    logic        imm_bad;

    always_comb begin
        enc_word = '0;
        fmt_bad  = 1'b0;
        case (in_fmt)
            2'd0: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD};
            2'd1: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OPC_STORE};
            // B format: in_imm counts halfwords, so in_imm[k] is offset bit k+1.
            2'd2: enc_word = {in_imm[11], in_imm[9:4], in_rs2, in_rs1, in_funct3,
                              in_imm[3:0], in_imm[10], OPC_BRANCH};
            default: fmt_bad = 1'b1;
        endcase
    end

`ifdef IMM_RANGE_CHECK_EN
    // In range exactly when the sign-extension bits [31:11] all match.
    assign imm_bad = !((&in_imm[31:11]) || !(|in_imm[31:11]));
`else
    logic unused_imm_hi;
    assign unused_imm_hi = ^in_imm[31:12];
    assign imm_bad = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    logic             ready_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             full, empty;
    logic             accept, drop, push, pop;

    assign full   = (count_q == FULL_COUNT);
    assign empty  = (count_q == '0);

    // ready_q holds in_ready low through reset and releases it on the
    // first clock edge after reset is removed.
    assign in_ready = ready_q && !full;
    assign accept   = in_valid && in_ready;
    assign drop     = fmt_bad || imm_bad;
    assign push     = accept && !drop;
    assign pop      = mem_req && mem_gnt;

    // ------------------------------------------------------------------
    // FIFO storage (contents need no reset; validity lives in count_q)
    // ------------------------------------------------------------------
    logic [31:0] word_mem [DEPTH];
    logic        last_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            word_mem[wr_ptr_q] <= enc_word;
            last_mem[wr_ptr_q] <= in_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap without a compare.
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Address counter and status
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] addr_q, addr_d, addr_inc;
    logic              addr_carry;
    logic              done_q, err_q, wrap_q;

    always_comb begin
        {addr_carry, addr_inc} = {1'b0, addr_q} + (ADDR_W+1)'(4);
        addr_d = addr_q;
        if (pop) addr_d = addr_carry ? BASE : addr_inc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            addr_q  <= BASE;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            addr_q  <= addr_d;
            done_q  <= pop && last_mem[rd_ptr_q];
            err_q   <= err_q || (accept && drop);
            wrap_q  <= wrap_q || (pop && addr_carry);
        end
    end

    // Head and address are registered, so they stay stable while a write stalls.
    assign mem_req   = !empty;
    assign mem_addr  = addr_q;
    assign mem_wdata = word_mem[rd_ptr_q];
    assign done      = done_q;
    assign err       = err_q;
    assign wrap      = wrap_q;

endmodule
